// File: rtl/score_keeper.sv
// score_keeper
//
// Game-state and score accumulator for Piano Tiles. Counts tile hits and
// misses while a game is running, sequences IDLE -> PLAY -> OVER, keeps a
// session high score and publishes a frame-stable copy of the live score
// so the two-digit renderer never tears mid-frame.
//
// Parameters:
//   MAX_SCORE   saturation value and win threshold (<= 63)
//   MAX_MISSES  number of misses that ends the game (1..3)
//
// Ports:
//   Clk          in   1  system (pixel) clock
//   Reset_n      in   1  asynchronous active-low reset
//   start        in   1  pulse, begins a new game from IDLE or OVER
//   hit          in   1  pulse, correct tile pressed
//   miss         in   1  pulse, tile missed or wrong key
//   frame_start  in   1  pulse at start of vertical blank
//   score        out  6  live score sampled at frame boundaries
//   high_score   out  6  best final score since reset
//   misses       out  2  misses in the current game (live)
//   playing      out  1  high while in PLAY
//   game_over    out  1  high while in OVER
module score_keeper #(
  parameter int MAX_SCORE  = 63,
  parameter int MAX_MISSES = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       frame_start,
  output logic [5:0] score,
  output logic [5:0] high_score,
  output logic [1:0] misses,
  output logic       playing,
  output logic       game_over
);

  localparam logic [5:0] SCORE_CAP = 6'(MAX_SCORE);
  localparam logic [1:0] MISS_CAP  = 2'(MAX_MISSES);

  // Encoding chosen so each status output is a single state flop bit,
  // which keeps playing/game_over glitch-free without extra registers.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [5:0] live_score;
  logic [5:0] live_next;
  logic [1:0] miss_next;
  logic       game_ends;
  logic       game_begins;

  // Saturating next values of both counters as they would be after this
  // edge in PLAY; the end-of-game test looks at these so a simultaneous
  // hit is already included when a miss finishes the game.
  always_comb begin
    live_next = live_score;
    miss_next = misses;
    if (hit && (live_score < SCORE_CAP)) begin
      live_next = live_score + 6'd1;
    end
    if (miss && (misses < MISS_CAP)) begin
      miss_next = misses + 2'd1;
    end
    game_ends   = (miss_next >= MISS_CAP) || (live_next >= SCORE_CAP);
    game_begins = (state != PLAY) && start;
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start is ignored while a game is running.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = PLAY;
      PLAY:    if (game_ends) next_state = OVER;
      OVER:    if (start) next_state = PLAY;
      default: next_state = IDLE;
    endcase
  end

  // Output decode straight from state flop bits.
  always_comb begin
    playing   = state[0];
    game_over = state[1];
  end

  // Live counters: cleared on entry to PLAY (a coincident hit is dropped),
  // updated only while in PLAY.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      live_score <= 6'd0;
      misses     <= 2'd0;
    end else if (game_begins) begin
      live_score <= 6'd0;
      misses     <= 2'd0;
    end else if (state == PLAY) begin
      live_score <= live_next;
      misses     <= miss_next;
    end
  end

  // High score captures the final score on the same edge PLAY -> OVER.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      high_score <= 6'd0;
    end else if ((state == PLAY) && game_ends && (live_next > high_score)) begin
      high_score <= live_next;
    end
  end

  // Frame shadow: takes the registered live score, so a hit or start on
  // the frame_start edge shows up only at the following frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score <= 6'd0;
    end else if (frame_start) begin
      score <= live_score;
    end
  end

endmodule
